// File: rtl/prog_loader_ctrl.sv
// prog_loader_ctrl
//   Boot/run sequencer for the single-cycle RISC-V datapath. A host streams
//   header and payload words over a valid/ready port. The controller writes
//   payloads into instruction or data memory and holds the core in reset
//   while it loads. A RUN header releases the core. The controller then
//   declares the program finished when it sees HALT_WORD fetched at an
//   unchanged PC for HALT_CYCLES consecutive cycles.
//
//   Header word: [31:30] target (00 IMEM, 01 DMEM, 10 RUN, 11 reserved),
//                [29:16] start word index, [15:0] word count.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   cmd_valid/ready/data      host word stream
//   imem_we/waddr/wdata       instruction memory write port (registered)
//   dmem_we/waddr/wdata       data memory write port (registered)
//   core_rst_n                datapath reset, active-low
//   core_pc, core_instr       datapath fetch observation
//   busy, halted, err         status (err is sticky until rst)
//   cycle_count               core cycles executed since the last RUN
module prog_loader_ctrl #(
    parameter int          IMEM_DEPTH  = 64,
    parameter int          DMEM_DEPTH  = 64,
    parameter logic [31:0] HALT_WORD   = 32'h0000006f,
    parameter int          HALT_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [31:0]                   cmd_data,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    output logic [31:0]                   imem_wdata,
    output logic                          dmem_we,
    output logic [$clog2(DMEM_DEPTH)-1:0] dmem_waddr,
    output logic [31:0]                   dmem_wdata,
    output logic                          core_rst_n,
    input  logic [31:0]                   core_pc,
    input  logic [31:0]                   core_instr,
    output logic                          busy,
    output logic                          halted,
    output logic                          err,
    output logic [31:0]                   cycle_count
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);
    localparam int AW  = (IAW > DAW) ? IAW : DAW;
    localparam int HCW = $clog2(HALT_CYCLES + 1);
    localparam logic [16:0] IMEM_LIM = 17'(IMEM_DEPTH);
    localparam logic [16:0] DMEM_LIM = 17'(DMEM_DEPTH);
    localparam logic [HCW-1:0] HALT_LAST = HCW'(HALT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HALTED,
        S_ERR
    } state_t;

    state_t           state;
    logic             load_dmem;
    logic [AW-1:0]    ptr;
    logic [15:0]      remaining;
    logic [31:0]      prev_pc;
    logic             pc_valid;
    logic [HCW-1:0]   halt_cnt;

    logic             accept;
    logic [1:0]       hdr_tgt;
    logic [13:0]      hdr_s;
    logic [15:0]      hdr_n;
    logic [16:0]      hdr_end;
    logic             hdr_oob;
    logic             pc_stable;

    assign accept  = cmd_valid & cmd_ready;
    assign hdr_tgt = cmd_data[31:30];
    assign hdr_s   = cmd_data[29:16];
    assign hdr_n   = cmd_data[15:0];
    // 17-bit sum so that a large start plus a large count cannot wrap into range
    assign hdr_end = {3'b000, hdr_s} + {1'b0, hdr_n};
    assign hdr_oob = hdr_end > (hdr_tgt[0] ? DMEM_LIM : IMEM_LIM);

    // The first RUN cycle has no previous PC to compare against
    assign pc_stable = pc_valid && (core_pc == prev_pc) && (core_instr == HALT_WORD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b0;
            imem_we     <= 1'b0;
            imem_waddr  <= '0;
            imem_wdata  <= '0;
            dmem_we     <= 1'b0;
            dmem_waddr  <= '0;
            dmem_wdata  <= '0;
            core_rst_n  <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
            cycle_count <= '0;
            load_dmem   <= 1'b0;
            ptr         <= '0;
            remaining   <= '0;
            prev_pc     <= '0;
            pc_valid    <= 1'b0;
            halt_cnt    <= '0;
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            case (state)
                S_IDLE, S_HALTED: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        if (hdr_tgt == 2'b10) begin
                            state       <= S_RUN;
                            cmd_ready   <= 1'b0;
                            halted      <= 1'b0;
                            cycle_count <= '0;
                            halt_cnt    <= '0;
                            pc_valid    <= 1'b0;
                            // From HALTED the core gets a one-cycle reset pulse
                            core_rst_n  <= (state == S_IDLE);
                        end else begin
                            halted     <= 1'b0;
                            core_rst_n <= 1'b0;
                            if (hdr_tgt == 2'b11) begin
                                state     <= S_ERR;
                                err       <= 1'b1;
                                cmd_ready <= 1'b0;
                            end else if (hdr_n == 16'd0) begin
                                state <= S_IDLE;
                            end else if (hdr_oob) begin
                                state     <= S_ERR;
                                err       <= 1'b1;
                                cmd_ready <= 1'b0;
                            end else begin
                                state     <= S_LOAD;
                                busy      <= 1'b1;
                                load_dmem <= hdr_tgt[0];
                                ptr       <= hdr_s[AW-1:0];
                                remaining <= hdr_n;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (load_dmem) begin
                            dmem_we    <= 1'b1;
                            dmem_waddr <= ptr[DAW-1:0];
                            dmem_wdata <= cmd_data;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_waddr <= ptr[IAW-1:0];
                            imem_wdata <= cmd_data;
                        end
                        ptr       <= ptr + AW'(1);
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    core_rst_n  <= 1'b1;
                    cycle_count <= cycle_count + 32'd1;
                    prev_pc     <= core_pc;
                    pc_valid    <= 1'b1;
                    if (pc_stable) begin
                        halt_cnt <= halt_cnt + HCW'(1);
                        if (halt_cnt == HALT_LAST) begin
                            state     <= S_HALTED;
                            halted    <= 1'b1;
                            cmd_ready <= 1'b1;
                        end
                    end else begin
                        halt_cnt <= '0;
                    end
                end
                S_ERR: begin
                    cmd_ready  <= 1'b0;
                    core_rst_n <= 1'b0;
                end
                default: state <= S_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Testbench for prog_loader_ctrl: randomized loads against a memory-image
// reference model, a simple PC-stepping core stand-in, error and reset paths.
module tb_prog_loader_ctrl;

    localparam logic [31:0] HALT = 32'h0000006f;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_data = '0;
    logic        imem_we, dmem_we;
    logic [5:0]  imem_waddr, dmem_waddr;
    logic [31:0] imem_wdata, dmem_wdata;
    logic        core_rst_n;
    logic [31:0] core_pc;
    logic [31:0] core_instr;
    logic        busy, halted, err;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_loader_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
        .core_rst_n(core_rst_n), .core_pc(core_pc), .core_instr(core_instr),
        .busy(busy), .halted(halted), .err(err), .cycle_count(cycle_count)
    );

    // Memories as written by the DUT, and the image the host intended
    logic [31:0] got_imem [64];
    logic [31:0] got_dmem [64];
    logic [31:0] model_imem [64];
    logic [31:0] model_dmem [64];
    int imem_wr_cnt = 0, dmem_wr_cnt = 0;
    int imem_addr_q[$];
    int dmem_addr_q[$];

    always @(negedge clk) begin
        if (imem_we) begin
            got_imem[imem_waddr] = imem_wdata;
            imem_wr_cnt++;
            imem_addr_q.push_back(int'(imem_waddr));
        end
        if (dmem_we) begin
            got_dmem[dmem_waddr] = dmem_wdata;
            dmem_wr_cnt++;
            dmem_addr_q.push_back(int'(dmem_waddr));
        end
    end

    // Core stand-in: straight-line fetch from 0 until it parks at 0xA0
    always @(posedge clk) begin
        if (!core_rst_n) core_pc <= 32'h0;
        else if (core_pc != 32'hA0) core_pc <= core_pc + 32'd4;
    end
    assign core_instr = got_imem[core_pc[7:2]];

    function automatic logic [31:0] hdr(input logic [1:0] t, input int s, input int n);
        return {t, 14'(s), 16'(n)};
    endfunction

    task automatic clear_mon();
        imem_wr_cnt = 0;
        dmem_wr_cnt = 0;
        imem_addr_q.delete();
        dmem_addr_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Presents one word; returns 1 ns after the accepting edge
    task automatic send(input logic [31:0] w, input bit gap);
        int n;
        @(negedge clk);
        if (gap) begin
            cmd_valid = 1'b0;
            @(negedge clk);
        end
        cmd_valid = 1'b1;
        cmd_data  = w;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Loads N words at S into target t; updates the model image
    task automatic load(input logic [1:0] t, input int s, input int n,
                        input bit gaps, input bit rand_gaps);
        logic [31:0] w;
        send(hdr(t, s, n), 1'b0);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (w == HALT) w = 32'h1;
            if (t == 2'b00) model_imem[s + i] = w;
            else model_dmem[s + i] = w;
            send(w, gaps | (rand_gaps && ($urandom_range(0, 3) == 0)));
        end
        @(negedge clk);
        #1;
    endtask

    task automatic check_writes(input string name, input bit dmem, input int s, input int n);
        int bad_addr, bad_data, cnt;
        bad_addr = 0;
        bad_data = 0;
        cnt = dmem ? dmem_wr_cnt : imem_wr_cnt;
        checks++;
        if (cnt !== n) begin
            errors++;
            $display("FAIL %s_count: got %0d writes required %0d", name, cnt, n);
        end
        for (int i = 0; i < n; i++) begin
            int a;
            a = dmem ? (i < dmem_addr_q.size() ? dmem_addr_q[i] : -1)
                     : (i < imem_addr_q.size() ? imem_addr_q[i] : -1);
            if (a != s + i) bad_addr++;
            if (dmem ? (got_dmem[s + i] !== model_dmem[s + i])
                     : (got_imem[s + i] !== model_imem[s + i])) bad_data++;
        end
        checks++;
        if (bad_addr != 0) begin
            errors++;
            $display("FAIL %s_addr_order: %0d addresses out of order, required 0", name, bad_addr);
        end
        checks++;
        if (bad_data != 0) begin
            errors++;
            $display("FAIL %s_data: %0d words differ, required 0", name, bad_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, busy, halted, err, core_rst_n, imem_we, dmem_we} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {cmd_ready, busy, halted, err, core_rst_n, imem_we, dmem_we});
        end
        checks++;
        if (cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_cycle_count: got %0d required 0", cycle_count);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: cmd_ready=%0b busy=%0b required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_imem_load();
        logic [31:0] w;
        clear_mon();
        send(hdr(2'b00, 0, 41), 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL imem_busy: got %0b required 1", busy);
        end
        for (int i = 0; i < 41; i++) begin
            w = $urandom;
            if (w == HALT) w = 32'h13;
            if (i == 40) w = HALT;
            model_imem[i] = w;
            send(w, $urandom_range(0, 3) == 0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL imem_busy_end: got %0b required 0", busy);
        end
        @(negedge clk);
        #1;
        check_writes("imem", 1'b0, 0, 41);
        checks++;
        if (got_imem[40] !== HALT) begin
            errors++;
            $display("FAIL imem_last: got %h required %h", got_imem[40], HALT);
        end
        checks++;
        if (dmem_wr_cnt != 0) begin
            errors++;
            $display("FAIL imem_no_dmem: got %0d dmem writes required 0", dmem_wr_cnt);
        end
    endtask

    task automatic test_dmem_gaps();
        logic [31:0] vals [5];
        int s, n;
        vals = '{32'd5, 32'd10, 32'd20, 32'd30, 32'd40};
        clear_mon();
        send(hdr(2'b01, 0, 5), 1'b0);
        for (int i = 0; i < 5; i++) begin
            model_dmem[i] = vals[i];
            send(vals[i], 1'b1);
            if (i == 3) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL dmem_busy_mid: got %0b required 1", busy);
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL dmem_busy_end: got %0b required 0", busy);
        end
        @(negedge clk);
        #1;
        check_writes("dmem_gap", 1'b1, 0, 5);
        checks++;
        if (imem_wr_cnt != 0) begin
            errors++;
            $display("FAIL dmem_no_imem: got %0d imem writes required 0", imem_wr_cnt);
        end
        // Random region above the result area, random gaps
        s = $urandom_range(8, 40);
        n = $urandom_range(1, 64 - s);
        clear_mon();
        load(2'b01, s, n, 1'b0, 1'b1);
        check_writes("dmem_rand", 1'b1, s, n);
    endtask

    function automatic int model_halt_cycle();
        int stable;
        logic [31:0] pc, prev;
        stable = 0;
        prev = '0;
        for (int t = 1; t <= 400; t++) begin
            pc = (4 * (t - 1) < 32'hA0) ? 32'(4 * (t - 1)) : 32'hA0;
            if (t > 1 && pc == prev && model_imem[pc[7:2]] == HALT) stable++;
            else stable = 0;
            if (stable == 2) return t;
            prev = pc;
        end
        return -1;
    endfunction

    task automatic test_run_halt();
        int exp_t, t;
        exp_t = model_halt_cycle();
        send(hdr(2'b10, 0, 0), 1'b0);
        checks++;
        if (core_rst_n !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_start: core_rst_n=%0b cmd_ready=%0b required 1 0",
                     core_rst_n, cmd_ready);
        end
        t = 0;
        while (halted !== 1'b1 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (t !== exp_t) begin
            errors++;
            $display("FAIL halt_latency: got %0d cycles required %0d", t, exp_t);
        end
        checks++;
        if (cycle_count !== 32'(exp_t)) begin
            errors++;
            $display("FAIL halt_cycle_count: got %0d required %0d", cycle_count, exp_t);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (cycle_count !== 32'(exp_t) || halted !== 1'b1 || core_rst_n !== 1'b1
            || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL halted_hold: count=%0d halted=%0b core_rst_n=%0b ready=%0b required %0d 1 1 1",
                     cycle_count, halted, core_rst_n, cmd_ready, exp_t);
        end
        checks++;
        if (got_dmem[2] !== 32'd20) begin
            errors++;
            $display("FAIL dmem_result: got %0d required 20", got_dmem[2]);
        end
    endtask

    task automatic test_reload_from_halted();
        clear_mon();
        send(hdr(2'b00, 50, 4), 1'b0);
        checks++;
        if (core_rst_n !== 1'b0 || halted !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reload_enter: core_rst_n=%0b halted=%0b busy=%0b required 0 0 1",
                     core_rst_n, halted, busy);
        end
        for (int i = 0; i < 4; i++) begin
            model_imem[50 + i] = $urandom;
            send(model_imem[50 + i], 1'b0);
        end
        @(negedge clk);
        #1;
        check_writes("reload", 1'b0, 50, 4);
    endtask

    task automatic test_zero_count();
        clear_mon();
        send(hdr(2'b01, 5, 0), 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || err !== 1'b0
            || (imem_wr_cnt + dmem_wr_cnt) != 0) begin
            errors++;
            $display("FAIL zero_count: busy=%0b ready=%0b err=%0b writes=%0d required 0 1 0 0",
                     busy, cmd_ready, err, imem_wr_cnt + dmem_wr_cnt);
        end
    endtask

    task automatic test_errors();
        do_reset();
        clear_mon();
        send(hdr(2'b00, 60, 8), 1'b0);
        checks++;
        if (err !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL oob_err: err=%0b ready=%0b required 1 0", err, cmd_ready);
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b1 || core_rst_n !== 1'b0 || (imem_wr_cnt + dmem_wr_cnt) != 0) begin
            errors++;
            $display("FAIL err_sticky: err=%0b core_rst_n=%0b writes=%0d required 1 0 0",
                     err, core_rst_n, imem_wr_cnt + dmem_wr_cnt);
        end
        do_reset();
        checks++;
        if (err !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: err=%0b ready=%0b required 0 1", err, cmd_ready);
        end
        send(hdr(2'b11, 0, 1), 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL reserved_err: got %0b required 1", err);
        end
        do_reset();
        // Exactly at the top of memory is legal
        clear_mon();
        load(2'b00, 56, 8, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL edge_no_err: got %0b required 0", err);
        end
        check_writes("edge", 1'b0, 56, 8);
    endtask

    task automatic test_async_reset();
        clear_mon();
        send(hdr(2'b00, 10, 10), 1'b0);
        send(32'hAAAA0001, 1'b0);
        send(32'hAAAA0002, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = 32'hAAAA0003;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, busy, halted, err, core_rst_n, imem_we, dmem_we} !== 7'b0
            || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: flags=%b count=%0d required 0000000 0",
                     {cmd_ready, busy, halted, err, core_rst_n, imem_we, dmem_we}, cycle_count);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
        load(2'b01, 20, 3, 1'b0, 1'b0);
        check_writes("after_reset", 1'b1, 20, 3);
        checks++;
        if (busy !== 1'b0 || imem_wr_cnt != 0) begin
            errors++;
            $display("FAIL after_reset_idle: busy=%0b imem_writes=%0d required 0 0",
                     busy, imem_wr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_imem_load();
        test_dmem_gaps();
        test_run_halt();
        test_reload_from_halted();
        test_zero_count();
        test_errors();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/prog_loader_ctrl.md
Name: prog_loader_ctrl

Overview:
- Boot/run sequencer for the single-cycle RISC-V datapath.
- Accepts a word stream over a valid/ready port and writes it into instruction memory and data memory through their write ports.
- Holds the core in reset during loading, releases it on a RUN command, and detects program completion: a self-loop `jal x0,0` at a stable PC.
- Sits between an external host/debug link and the datapath, replacing hierarchical memory preloading.

Parameters:
- IMEM_DEPTH, 64, instruction memory depth in 32-bit words.
- DMEM_DEPTH, 64, data memory depth in 32-bit words.
- HALT_WORD, 32'h0000006f, instruction encoding treated as halt.
- HALT_CYCLES, 2, consecutive cycles of HALT_WORD at an unchanged PC required to declare halt.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  host word valid.
- cmd_ready  out  1  controller can accept a word.
- cmd_data  in  32  header or payload word.
- imem_we  out  1  instruction memory write strobe.
- imem_waddr  out  $clog2(IMEM_DEPTH)  instruction memory word index.
- imem_wdata  out  32  instruction memory write data.
- dmem_we  out  1  data memory write strobe.
- dmem_waddr  out  $clog2(DMEM_DEPTH)  data memory word index.
- dmem_wdata  out  32  data memory write data.
- core_rst_n  out  1  datapath reset, active-low.
- core_pc  in  32  current datapath PC.
- core_instr  in  32  instruction currently fetched.
- busy  out  1  high in LOAD.
- halted  out  1  program completed.
- err  out  1  sticky protocol error.
- cycle_count  out  32  core cycles executed since the last RUN.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - All outputs 0, including core_rst_n=0 and cycle_count=0.
  - Taking effect mid-load or mid-run aborts immediately; memory contents already written are not cleared.
- Transfer: a word is accepted on a rising edge with cmd_valid & cmd_ready.
- Header format:
  - [31:30] target: 00 IMEM, 01 DMEM, 10 RUN, 11 reserved.
  - [29:16] start word index S.
  - [15:0] word count N.
- States:
  - IDLE: cmd_ready=1.
    - Header with target IMEM/DMEM and N>0 → LOAD; base=S, remaining=N.
    - N=0 → stay in IDLE, no effect.
    - S+N > depth of the target → ERR.
    - Target 11 → ERR.
    - RUN → RUN.
  - LOAD: cmd_ready=1, busy=1.
    - Each accepted word is written to the target at index base+i.
    - Write strobe, address and data are registered: the word accepted at edge k produces we=1 for exactly the cycle after edge k.
    - The other memory's strobe stays 0.
    - After word N is accepted → IDLE; its write still issues on the next cycle.
    - Back-to-back words give one write per cycle.
    - cmd_valid low inserts idle cycles with no writes.
  - RUN: cmd_ready=0.
    - core_rst_n=1 from the cycle after the RUN header is accepted.
    - cycle_count increments every cycle while in RUN.
    - Halt counter: increments when core_instr==HALT_WORD and core_pc equals the previous cycle's PC; any other cycle clears it.
    - Counter reaching HALT_CYCLES → HALTED.
  - HALTED: halted=1.
    - core_rst_n stays 1; the core spins harmlessly.
    - cycle_count is frozen.
    - cmd_ready=1.
    - IMEM/DMEM header: core_rst_n=0 and halted=0 on the next cycle, then → LOAD, following IDLE header rules.
    - RUN header: pulses core_rst_n low for 1 cycle, clears cycle_count, → RUN.
  - ERR: err=1, cmd_ready=0, core_rst_n=0. Exit only by rst.
- Width rules:
  - Header fields are zero-extended.
  - The bound check S+N is computed in 17 bits, so no wrap-around.
  - cycle_count wraps modulo 2^32.
- Simultaneous events: none are possible, because RUN blocks the command port.

Test Plan:
- IMEM load: header {00, S=0, N=41} followed by the 41 program words (fe010113 … 0000006f) → exactly 41 imem_we pulses, addresses 0..40 in order; memory[40]=0000006f; dmem_we never asserted.
- DMEM load with gaps: header {01, S=0, N=5}, words 5,10,20,30,40, cmd_valid toggled every other cycle → 5 writes at indices 0..4; no write in gap cycles; busy falls after the last accept.
- Run and halt: after both loads, send RUN → core_rst_n rises the next cycle; core reaches PC=0xA0 executing 0000006f → halted=1 after 2 stable cycles; cycle_count frozen; data memory index 2 matches the software result.
- Error paths:
  - header {00, S=60, N=8} (68>64) → err=1, cmd_ready=0, no writes;
  - reserved target 11 → err=1;
  - err is cleared only by rst.
- Zero count and reload: header N=0 → stays IDLE, no writes. From HALTED, an IMEM header → core_rst_n=0 and halted=0 on the next cycle, then load proceeds.
- Async reset mid-load: assert rst=0 between edges during word 3 of 10 → all outputs 0 immediately, state IDLE; the next header is accepted normally.
